// File: rtl/bus_demux2_pkg.sv
// rtl/bus_demux2_pkg.sv - shared encodings and memory-map defaults for the 1:2 bus router
package bus_demux2_pkg;

    localparam int DEF_ADDR_WIDTH = 30;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 255;

    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_S1_BASE = 30'h3C00_0000;
    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_S1_MASK = 30'h3F00_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/bus_demux2_if.sv
// rtl/bus_demux2_if.sv - word-addressed memory bus port with request/ack handshake
interface bus_demux2_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ready;
    logic                    error;

    // Side that issues requests
    modport master (
        output addr, wdata, be, read, write,
        input  rdata, ready, error
    );

    // Side that services requests
    modport slave (
        input  addr, wdata, be, read, write,
        output rdata, ready, error
    );
endinterface

// File: rtl/bus_demux2_mux2.sv
// rtl/bus_demux2_mux2.sv - 2:1 data select feeding the read-data capture register
module bus_demux2_mux2 #(
    parameter int DW = 32
) (
    input  logic          sel_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    // sel_i=0 picks slave 0 data, sel_i=1 picks slave 1 data
    always_comb begin
        y_o = sel_i ? b_i : a_i;
    end

endmodule

// File: rtl/bus_demux2.sv
// rtl/bus_demux2.sv - 1-master to 2-slave memory-bus router with slave timeout
module bus_demux2
    import bus_demux2_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = DEF_S1_BASE,
    parameter logic [ADDR_WIDTH-1:0] S1_MASK    = DEF_S1_MASK,
    parameter int                    TIMEOUT    = DEF_TIMEOUT
) (
    input logic          clk_i,
    input logic          rst_i,
    bus_demux2_if.slave  m_bus,
    bus_demux2_if.master s0_bus,
    bus_demux2_if.master s1_bus
);

    localparam int BW = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic                  route_q, route_d;
    op_e                   op_q, op_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
    logic [DATA_WIDTH-1:0] s0_wdata_q, s0_wdata_d;
    logic [BW-1:0]         s0_be_q, s0_be_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_wdata_q, s1_wdata_d;
    logic [BW-1:0]         s1_be_q, s1_be_d;

    logic                  busy;
    logic                  req_route;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timeout_hit;

    assign busy      = (state_q == ST_BUSY);
    assign req_route = ((m_bus.addr & S1_MASK) == S1_BASE);
    assign sel_ready = route_q ? s1_bus.ready : s0_bus.ready;

    bus_demux2_mux2 #(
        .DW(DATA_WIDTH)
    ) u_rdata_mux (
        .sel_i(route_q),
        .a_i  (s0_bus.rdata),
        .b_i  (s1_bus.rdata),
        .y_o  (sel_rdata)
    );

    // A hung slave is cut loose after TIMEOUT busy cycles; TIMEOUT=0 removes the counter
    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt_q, cnt_d;

            // Count busy cycles, clear whenever the transaction is not outstanding
            always_comb begin
                cnt_d = busy ? cnt_q + CW'(1) : '0;
            end

            // Counter register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign timeout_hit = busy && (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Next-state logic: latch request in IDLE, wait for ack or timeout in BUSY, ack in DONE
    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        op_d       = op_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        s0_addr_d  = s0_addr_q;
        s0_wdata_d = s0_wdata_q;
        s0_be_d    = s0_be_q;
        s1_addr_d  = s1_addr_q;
        s1_wdata_d = s1_wdata_q;
        s1_be_d    = s1_be_q;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (m_bus.write || m_bus.read) begin
                    route_d = req_route;
                    op_d    = m_bus.write ? OP_WRITE : OP_READ;
                    state_d = ST_BUSY;
                    // Only the routed slave sees the new request fields
                    if (req_route) begin
                        s1_addr_d  = m_bus.addr;
                        s1_wdata_d = m_bus.wdata;
                        s1_be_d    = m_bus.be;
                    end else begin
                        s0_addr_d  = m_bus.addr;
                        s0_wdata_d = m_bus.wdata;
                        s0_be_d    = m_bus.be;
                    end
                end
            end
            ST_BUSY: begin
                // Ack takes priority over a timeout landing in the same cycle
                if (sel_ready) begin
                    rdata_d = (op_q == OP_WRITE) ? '0 : sel_rdata;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            route_q    <= 1'b0;
            op_q       <= OP_READ;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            s0_addr_q  <= '0;
            s0_wdata_q <= '0;
            s0_be_q    <= '0;
            s1_addr_q  <= '0;
            s1_wdata_q <= '0;
            s1_be_q    <= '0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            op_q       <= op_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            s0_addr_q  <= s0_addr_d;
            s0_wdata_q <= s0_wdata_d;
            s0_be_q    <= s0_be_d;
            s1_addr_q  <= s1_addr_d;
            s1_wdata_q <= s1_wdata_d;
            s1_be_q    <= s1_be_d;
        end
    end

    // Strobes decode from registered state so an async reset drops them at once
    assign s0_bus.read  = busy && !route_q && (op_q == OP_READ);
    assign s0_bus.write = busy && !route_q && (op_q == OP_WRITE);
    assign s1_bus.read  = busy &&  route_q && (op_q == OP_READ);
    assign s1_bus.write = busy &&  route_q && (op_q == OP_WRITE);

    assign s0_bus.addr  = s0_addr_q;
    assign s0_bus.wdata = s0_wdata_q;
    assign s0_bus.be    = s0_be_q;
    assign s1_bus.addr  = s1_addr_q;
    assign s1_bus.wdata = s1_wdata_q;
    assign s1_bus.be    = s1_be_q;

    assign m_bus.ready  = (state_q == ST_DONE);
    assign m_bus.error  = (state_q == ST_DONE) && err_q;
    assign m_bus.rdata  = rdata_q;

endmodule
